// File: rtl/mnist_frame_buffer_if.sv
// Pixel-stream and frame-handoff signals between the raster source, the frame
// buffer and the MLP consumer.
interface mnist_frame_buffer_if #(
  parameter int pixels_number = 784,
  parameter int resolution    = 8
);
  logic [resolution-1:0]               in_pixel;
  logic                                in_valid;
  logic                                in_sof;
  logic                                in_ready;
  logic [resolution*pixels_number-1:0] pixels;
  logic                                frame_valid;
  logic                                frame_ack;
  logic                                sync_err;
  logic [15:0]                         frame_count;

  modport master (
    output in_pixel, in_valid, in_sof, frame_ack,
    input  in_ready, pixels, frame_valid, sync_err, frame_count
  );

  modport slave (
    input  in_pixel, in_valid, in_sof, frame_ack,
    output in_ready, pixels, frame_valid, sync_err, frame_count
  );
endinterface

// File: rtl/mnist_frame_buffer.sv
// Collects one raster frame of grayscale pixels, converts each to a non-negative
// signed byte and presents the packed frame until the consumer acknowledges it.
module mnist_frame_buffer #(
  parameter int pixels_number = 784,
  parameter int resolution    = 8,
  parameter bit INVERT        = 1'b0
) (
  input  logic                 clk,
  input  logic                 reset,
  mnist_frame_buffer_if.slave  bus
);
  localparam int idx_w = $clog2(pixels_number);
  localparam logic [idx_w-1:0] last_idx = idx_w'(pixels_number - 1);

  typedef enum logic [1:0] {IDLE, FILL, FULL} state_t;

  state_t                              state_q, state_d;
  logic [idx_w-1:0]                    idx_q, idx_d;
  logic [resolution*pixels_number-1:0] pixels_q;
  logic                                sync_err_q, sync_err_d;
  logic [15:0]                         count_q, count_d;
  logic                                wr_en;
  logic [idx_w-1:0]                    wr_idx;
  logic                                accept;
  logic [resolution-1:0]               level;
  logic [resolution-1:0]               stored;

  // Inversion is max - pixel, which for an all-ones maximum is a bitwise NOT.
  assign level  = INVERT ? ~bus.in_pixel : bus.in_pixel;
  assign stored = level >> 1;

  assign bus.in_ready    = (state_q != FULL);
  assign bus.frame_valid = (state_q == FULL);
  assign bus.pixels      = pixels_q;
  assign bus.sync_err    = sync_err_q;
  assign bus.frame_count = count_q;
  assign accept          = bus.in_valid && bus.in_ready;

  // NOTE: every signal assigned here gets a default first so no latch is inferred.
  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    count_d    = count_q;
    sync_err_d = 1'b0;
    wr_en      = 1'b0;
    wr_idx     = idx_q;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          if (bus.in_sof) begin
            wr_en   = 1'b1;
            wr_idx  = '0;
            idx_d   = idx_w'(1);
            state_d = FILL;
          end else begin
            sync_err_d = 1'b1;
          end
        end
      end
      FILL: begin
        if (accept) begin
          wr_en = 1'b1;
          if (bus.in_sof) begin
            // Resync: restart at pixel 0; stale pixels are simply overwritten later.
            wr_idx     = '0;
            idx_d      = idx_w'(1);
            sync_err_d = 1'b1;
          end else if (idx_q == last_idx) begin
            idx_d   = '0;
            state_d = FULL;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      FULL: begin
        if (bus.frame_ack) begin
          idx_d   = '0;
          count_d = count_q + 16'd1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= IDLE;
      idx_q      <= '0;
      sync_err_q <= 1'b0;
      count_q    <= '0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      sync_err_q <= sync_err_d;
      count_q    <= count_d;
    end
  end

  // NOTE: the frame store is a flop array, not RAM, so it can be cleared on reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      pixels_q <= '0;
    end else if (wr_en) begin
      pixels_q[wr_idx*resolution +: resolution] <= stored;
    end
  end
endmodule

// File: tb/tb_mnist_frame_buffer.sv
// Directed and randomized checks of mnist_frame_buffer; a plain-INVERT and an
// inverting instance receive the same stream and are checked against one model.
module tb_mnist_frame_buffer;
  localparam int N = 784;
  localparam int W = 8 * N;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  mnist_frame_buffer_if #(.pixels_number(N), .resolution(8)) bus ();
  mnist_frame_buffer_if #(.pixels_number(N), .resolution(8)) bus_inv ();

  assign bus_inv.in_pixel  = bus.in_pixel;
  assign bus_inv.in_valid  = bus.in_valid;
  assign bus_inv.in_sof    = bus.in_sof;
  assign bus_inv.frame_ack = bus.frame_ack;

  mnist_frame_buffer #(.pixels_number(N), .resolution(8), .INVERT(1'b0)) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );
  mnist_frame_buffer #(.pixels_number(N), .resolution(8), .INVERT(1'b1)) dut_inv (
    .clk(clk), .reset(reset), .bus(bus_inv)
  );

  // Reference model: stored images as byte arrays, fill position, full flag, count.
  logic [7:0] mem   [N];
  logic [7:0] mem_i [N];
  int         mpos;    // -1 when waiting for a start of frame
  bit         mfull;
  int         mcount;
  bit         exp_sync;

  int n_asserts = 0;
  int n_fail    = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [W-1:0] model_frame(input bit inv);
    logic [W-1:0] r;
    for (int k = 0; k < N; k++) r[8*k +: 8] = inv ? mem_i[k] : mem[k];
    return r;
  endfunction

  task automatic check_frame(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    int first_bad;
    first_bad = -1;
    for (int k = N - 1; k >= 0; k--) if (obs[8*k +: 8] !== exp[8*k +: 8]) first_bad = k;
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: pixel %0d observed %0h expected %0h", tag, first_bad,
             obs[8*first_bad +: 8], exp[8*first_bad +: 8]);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < N; k++) begin
      mem[k]   = 8'h00;
      mem_i[k] = 8'h00;
    end
    mpos = -1; mfull = 0; mcount = 0; exp_sync = 0;
  endtask

  // One offered beat, starting and ending at a falling edge.
  task automatic beat(input logic [7:0] p, input logic sof);
    bit acc;
    bus.in_valid = 1'b1;
    bus.in_pixel = p;
    bus.in_sof   = sof;
    check("in_ready", 32'(bus.in_ready), 32'(!mfull));
    acc = !mfull;
    @(posedge clk);
    exp_sync = 0;
    if (acc) begin
      if (sof || mpos < 0) begin
        if (sof) begin
          mem[0] = p >> 1; mem_i[0] = (8'd255 - p) >> 1;
          exp_sync = (mpos >= 0);
          mpos = 1;
        end else begin
          exp_sync = 1;
        end
      end else begin
        mem[mpos] = p >> 1; mem_i[mpos] = (8'd255 - p) >> 1;
        mpos++;
        if (mpos == N) begin
          mfull = 1;
          mpos  = -1;
        end
      end
    end
    @(negedge clk);
    check("sync_err", 32'(bus.sync_err), 32'(exp_sync));
    check("frame_valid", 32'(bus.frame_valid), 32'(mfull));
  endtask

  task automatic idle_cycle();
    bus.in_valid = 1'b0;
    @(posedge clk);
    if (bus.frame_ack && mfull) begin
      mfull = 0; mcount++;
    end
    @(negedge clk);
    check("idle_sync_err", 32'(bus.sync_err), 32'd0);
    check("idle_frame_valid", 32'(bus.frame_valid), 32'(mfull));
  endtask

  task automatic ack();
    bus.frame_ack = 1'b1;
    @(posedge clk);
    if (mfull) begin
      mfull = 0; mcount++;
    end
    @(negedge clk);
    bus.frame_ack = 1'b0;
    check("ack_frame_valid", 32'(bus.frame_valid), 32'(mfull));
    check("ack_frame_count", 32'(bus.frame_count), 32'(mcount));
    check("ack_in_ready", 32'(bus.in_ready), 32'd1);
  endtask

  task automatic check_both(input string tag);
    check_frame({tag, "_plain"}, bus.pixels, model_frame(0));
    check_frame({tag, "_inv"}, bus_inv.pixels, model_frame(1));
  endtask

  initial begin
    bus.in_valid = 0; bus.in_pixel = 0; bus.in_sof = 0; bus.frame_ack = 0;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    check("rst_in_ready", 32'(bus.in_ready), 32'd1);
    check("rst_frame_valid", 32'(bus.frame_valid), 32'd0);
    check("rst_frame_count", 32'(bus.frame_count), 32'd0);
    check("rst_sync_err", 32'(bus.sync_err), 32'd0);
    check_frame("rst_pixels", bus.pixels, '0);

    // Ramp frame, back-to-back beats.
    for (int k = 0; k < N; k++) beat(8'(k % 256), k == 0);
    check("a_valid", 32'(bus.frame_valid), 32'd1);
    check("a_in_ready", 32'(bus.in_ready), 32'd0);
    check("a_pix0", 32'(bus.pixels[7:0]), 32'h00);
    check("a_pix255", 32'(bus.pixels[8*255 +: 8]), 32'h7F);
    check("a_pix256", 32'(bus.pixels[8*256 +: 8]), 32'h00);
    check("a_pix783", 32'(bus.pixels[8*783 +: 8]), 32'h07);
    check_both("a");

    // Hold 50 cycles with a pending upstream beat that must not be taken.
    bus.in_valid = 1'b1; bus.in_sof = 1'b1; bus.in_pixel = 8'hAA;
    for (int c = 0; c < 50; c++) begin
      @(negedge clk);
      check_frame("hold_pixels", bus.pixels, model_frame(0));
      check("hold_valid", 32'(bus.frame_valid), 32'd1);
      check("hold_in_ready", 32'(bus.in_ready), 32'd0);
    end
    ack();
    check("a_count", 32'(bus.frame_count), 32'd1);

    // All-zero frame immediately after the ack.
    for (int k = 0; k < N; k++) beat(8'h00, k == 0);
    check_frame("zero_inv_const", bus_inv.pixels, {N{8'h7F}});
    check_frame("zero_plain_const", bus.pixels, '0);
    check_both("zero");
    ack();

    for (int k = 0; k < N; k++) beat(8'hFF, k == 0);
    check_frame("ff_inv_const", bus_inv.pixels, '0);
    check_frame("ff_plain_const", bus.pixels, {N{8'h7F}});
    check_both("ff");
    ack();

    // Beat without sof in IDLE is dropped with a single sync_err pulse.
    beat(8'h55, 1'b0);
    check("idle_err_pulse", 32'(bus.sync_err), 32'd1);
    idle_cycle();
    check("idle_err_clear", 32'(bus.sync_err), 32'd0);

    // Resync at beat 300, then a full frame after that sof.
    for (int k = 0; k < 300; k++) beat(8'($urandom), k == 0);
    beat(8'($urandom), 1'b1);
    check("resync_pulse", 32'(bus.sync_err), 32'd1);
    for (int k = 1; k < N; k++) beat(8'($urandom), 1'b0);
    check("resync_valid", 32'(bus.frame_valid), 32'd1);
    check_both("resync");
    ack();

    // Random gaps with early acknowledges that must be ignored.
    for (int k = 0; k < N; k++) begin
      while ($urandom_range(0, 9) < 3) begin
        bus.frame_ack = 1'($urandom_range(0, 1));
        idle_cycle();
      end
      bus.frame_ack = 1'($urandom_range(0, 1));
      beat(8'($urandom), k == 0);
    end
    bus.frame_ack = 1'b0;
    check("rand_valid", 32'(bus.frame_valid), 32'd1);
    check_both("rand");
    ack();
    check("rand_count", 32'(bus.frame_count), 32'd5);

    // Reset in the middle of a fill.
    for (int k = 0; k < 500; k++) beat(8'($urandom), k == 0);
    reset = 1'b0;
    bus.in_valid = 1'b1; bus.in_sof = 1'b0;
    @(posedge clk);
    model_reset();
    @(negedge clk);
    reset = 1'b1;
    check_frame("mid_rst_pixels", bus.pixels, '0);
    check("mid_rst_valid", 32'(bus.frame_valid), 32'd0);
    check("mid_rst_count", 32'(bus.frame_count), 32'd0);
    check("mid_rst_ready", 32'(bus.in_ready), 32'd1);
    for (int k = 0; k < N; k++) beat(8'($urandom), k == 0);
    check("post_rst_valid", 32'(bus.frame_valid), 32'd1);
    check_both("post_rst");
    ack();
    check("post_rst_count", 32'(bus.frame_count), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end
endmodule

// File: doc/mnist_frame_buffer.md
Name: mnist_frame_buffer

Overview:
- Upstream stage of the MLP: collects a raster stream of 8-bit grayscale pixels over a valid/ready handshake.
- Converts each pixel to the signed 8-bit format the MLP expects and packs a full frame into the flat pixels bus.
- Asserts frame_valid and holds the bus stable until the consumer acknowledges, then re-arms for the next frame.

Parameters:
- pixels_number, 784, pixels per frame (28x28 raster, row-major).
- resolution, 8, bits per input pixel and per stored pixel.
- INVERT, 0, when 1 each input pixel is replaced by 255 - pixel before conversion.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- reset  input  1  synchronous, active-low reset; sampled on the rising edge of clk.
- in_pixel  input  resolution  unsigned grayscale pixel, 0..255.
- in_valid  input  1  in_pixel/in_sof are valid this cycle.
- in_sof  input  1  start of frame; marks pixel index 0.
- in_ready  output  1  block can accept a beat this cycle.
- pixels  output  resolution*pixels_number  packed signed frame; pixel k at bits [8k+7:8k].
- frame_valid  output  1  pixels holds a complete frame.
- frame_ack  input  1  consumer has finished with the frame.
- sync_err  output  1  one-cycle pulse on a framing error.
- frame_count  output  16  number of frames acknowledged, wraps 65535 -> 0.

Behaviour:
- Beat accepted when in_valid && in_ready at a rising edge.
- Conversion: v = INVERT ? 255 - in_pixel : in_pixel; stored = {1'b0, v[7:1]}, range 0..127, never negative.
- Pixel index counter idx, width clog2(pixels_number).
- Reset (reset==0 at an edge):
  - state=IDLE, idx=0, pixels=0, frame_valid=0, sync_err=0, frame_count=0.
  - in_ready=1 from the first cycle after reset.
  - Reset overrides every other event, including mid-fill and while FULL.
- IDLE: in_ready=1.
  - Accepted beat with in_sof=1: write pixel 0, idx=1, go to FILL.
  - Accepted beat with in_sof=0: discarded, sync_err pulses, stay in IDLE.
- FILL: in_ready=1.
  - Accepted beat with in_sof=0: write pixel idx, idx+1.
  - When the beat written is idx==pixels_number-1: go to FULL and set frame_valid=1 at that same edge.
  - Accepted beat with in_sof=1: resync. Write pixel 0, idx=1, sync_err pulses, stay in FILL. Pixels from the aborted frame stay in the bus until overwritten and are never flagged valid.
  - No beat: hold.
- FULL: in_ready=0, frame_valid=1; pixels is stable and bit-identical every cycle.
  - in_valid beats are not accepted; the upstream must hold them.
  - frame_ack=1 at an edge: frame_valid=0, frame_count+1, idx=0, state=IDLE. The next frame's sof can be accepted the following cycle.
- frame_ack is ignored when frame_valid=0.
- Latency: last pixel accepted at edge N makes frame_valid high from edge N. Minimum frame period is pixels_number + 1 cycles (the ack cycle included).
- in_ready is a combinational function of state only (high in IDLE/FILL, low in FULL). It has no path from in_valid.
- sync_err is registered and high for exactly one cycle per error event.
- pixels is only written on accepted beats. It is not cleared on ack; the next frame overwrites it.

Test Plan:
- Reset then one frame, pixel k = k mod 256, in_valid always 1, INVERT=0, sof on beat 0:
  - frame_valid rises exactly 784 cycles after the first beat; pixel 0=0x00, pixel 255=0x7F, pixel 256=0x00, pixel 783=(783 mod 256)>>1=0x07.
  - in_ready=0 while frame_valid=1.
- Frame held 50 cycles, then frame_ack=1 for one cycle:
  - pixels unchanged for all 50 cycles; frame_valid=0 and frame_count=1 after the ack edge.
  - A second frame starting with sof on the next cycle is accepted.
- INVERT=1, all pixels 0x00:
  - every stored pixel = 0x7F; all-0xFF input gives all 0x00.
- Beat with in_sof=0 in IDLE:
  - sync_err pulses one cycle, beat dropped.
  - A sof at beat 300 of a FILL: sync_err pulses, a full 784 beats after that sof are needed for frame_valid.
- Random in_valid gaps (about 30% idle) plus frame_ack asserted before frame_valid:
  - early ack ignored; packed frame matches the reference model; frame_count increments once per frame.
- reset=0 for one cycle at beat 500 of a fill:
  - pixels=0, frame_valid=0, frame_count=0, state IDLE.
  - The following sof-started frame completes normally after 784 beats.
